// File: rtl/fifo_serial_tx.sv
// fifo_serial_tx: drains a synchronous FIFO onto an asynchronous serial line.
// Frame format: start (0), BITWIDTH data bits LSB-first, optional even parity, stop (1).
`timescale 1ns/1ps

module fifo_serial_tx #(
    parameter int unsigned BITWIDTH     = 5,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned PARITY_EN    = 1,
    parameter int unsigned COUNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                fifo_empty,
    input  logic [BITWIDTH-1:0] fifo_dout,
    output logic                fifo_rd_en,
    output logic                tx,
    output logic                busy,
    output logic                frame_done,
    output logic [COUNT_W-1:0]  frames_sent
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned IDX_W = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BITWIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    bit_cnt;
    logic [IDX_W-1:0]    bit_idx;
    logic [BITWIDTH-1:0] shift;
    logic [BITWIDTH-1:0] shift_next;
    logic                par_bit;
    logic                bit_end;
    logic                stop_pre_last;
    logic                pop;

    // Bit-period timing and the pop decision (pop only at idle or the final stop cycle)
    assign bit_end       = (bit_cnt == LAST_CNT);
    assign stop_pre_last = (CNT_W'(bit_cnt + 1'b1) == LAST_CNT);
    assign shift_next    = shift >> 1;
    assign pop           = enable & ~fifo_empty & ((state == IDLE) | ((state == STOP) & bit_end));
    assign fifo_rd_en    = pop & ~rst;

    // Frame sequencer: state, shift register and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            tx          <= 1'b1;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frames_sent <= '0;
            bit_cnt     <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            par_bit     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            bit_cnt    <= ((state == IDLE) || bit_end) ? '0 : CNT_W'(bit_cnt + 1'b1);

            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        state   <= START;
                        shift   <= fifo_dout;
                        par_bit <= ^fifo_dout;
                        bit_idx <= '0;
                        tx      <= 1'b0;
                        busy    <= 1'b1;
                    end
                end

                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        tx      <= shift[0];
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        shift <= shift_next;
                        if (bit_idx == LAST_IDX) begin
                            if (PARITY_EN != 0) begin
                                state <= PARITY;
                                tx    <= par_bit;
                            end else begin
                                state      <= STOP;
                                tx         <= 1'b1;
                                frame_done <= (CLKS_PER_BIT == 1);
                            end
                        end else begin
                            bit_idx <= IDX_W'(bit_idx + 1'b1);
                            tx      <= shift_next[0];
                        end
                    end
                end

                PARITY: begin
                    if (bit_end) begin
                        state      <= STOP;
                        tx         <= 1'b1;
                        frame_done <= (CLKS_PER_BIT == 1);
                    end
                end

                STOP: begin
                    if (!bit_end) begin
                        frame_done <= stop_pre_last;
                    end else begin
                        frames_sent <= COUNT_W'(frames_sent + 1'b1);
                        if (pop) begin
                            state   <= START;
                            shift   <= fifo_dout;
                            par_bit <= ^fifo_dout;
                            bit_idx <= '0;
                            tx      <= 1'b0;
                        end else begin
                            state <= IDLE;
                            tx    <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Scoreboard bench for fifo_serial_tx: stimulus queues FIFO words and expected frames,
// per-instance monitors rebuild each frame from tx and compare on frame_done.
`timescale 1ns/1ps

module tb_fifo_serial_tx;

    typedef struct {
        logic [4:0] word;
        int         cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // instance 1: default parameters
    logic        enable = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [4:0]  fifo_dout = '0;
    logic        fifo_rd_en, tx, busy, frame_done;
    logic [15:0] frames_sent;

    // instance 2: CLKS_PER_BIT=1, no parity, 2-bit counter
    logic        enable2 = 1'b0;
    logic        fifo_empty2 = 1'b1;
    logic [4:0]  fifo_dout2 = '0;
    logic        fifo_rd_en2, tx2, busy2, frame_done2;
    logic [1:0]  frames_sent2;

    int checks = 0;
    int errors = 0;

    logic [4:0] q1[$];
    logic [4:0] q2[$];
    exp_t       sb1[$];
    exp_t       sb2[$];
    int         exp_cnt1 = 0;
    int         exp_cnt2 = 0;

    logic samp1[$];
    logic samp2[$];
    int   pops1 = 0, pops2 = 0;
    int   busy_cyc1 = 0, busy_cyc2 = 0;
    int   busy_rise1 = 0, busy_rise2 = 0;
    logic busy_prev1 = 1'b0, busy_prev2 = 1'b0;
    int   pend1 = 0, pend2 = 0;
    bit   pend1_v = 1'b0, pend2_v = 1'b0;

    fifo_serial_tx dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done),
        .frames_sent(frames_sent)
    );

    fifo_serial_tx #(
        .BITWIDTH    (5),
        .CLKS_PER_BIT(1),
        .PARITY_EN   (0),
        .COUNT_W     (2)
    ) dut2 (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable2),
        .fifo_empty (fifo_empty2),
        .fifo_dout  (fifo_dout2),
        .fifo_rd_en (fifo_rd_en2),
        .tx         (tx2),
        .busy       (busy2),
        .frame_done (frame_done2),
        .frames_sent(frames_sent2)
    );

    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // expected tx level at sample k of a frame carrying word w
    function automatic logic exp_bit(input logic [4:0] w, input int k, input int cpb, input int pen);
        int b;
        b = k / cpb;
        if (b == 0) return 1'b0;
        if (b <= 5) return w[b-1];
        if (pen != 0 && b == 6) return ^w;
        return 1'b1;
    endfunction

    task automatic refresh();
        fifo_empty  = (q1.size() == 0);
        fifo_dout   = (q1.size() != 0) ? q1[0] : 5'd0;
        fifo_empty2 = (q2.size() == 0);
        fifo_dout2  = (q2.size() != 0) ? q2[0] : 5'd0;
    endtask

    task automatic tick();
        @(negedge clk);
        refresh();
    endtask

    task automatic push1(input logic [4:0] w, input bit expect_frame);
        exp_t e;
        q1.push_back(w);
        if (expect_frame) begin
            exp_cnt1 = (exp_cnt1 + 1) % 65536;
            e.word = w;
            e.cnt  = exp_cnt1;
            sb1.push_back(e);
        end
        refresh();
    endtask

    task automatic push2(input logic [4:0] w);
        exp_t e;
        q2.push_back(w);
        exp_cnt2 = (exp_cnt2 + 1) % 4;
        e.word = w;
        e.cnt  = exp_cnt2;
        sb2.push_back(e);
        refresh();
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        enable = 1'b0;
        q1.delete();
        sb1.delete();
        exp_cnt1 = 0;
        refresh();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // FIFO model pop and the never-pop-when-empty rule
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            check(!fifo_empty, "rd_en_while_empty", 1, 0);
            if (q1.size() != 0) void'(q1.pop_front());
            pops1++;
        end
        if (fifo_rd_en2) begin
            check(!fifo_empty2, "rd_en2_while_empty", 1, 0);
            if (q2.size() != 0) void'(q2.pop_front());
            pops2++;
        end
    end

    // Monitor for instance 1
    always @(negedge clk) begin
        exp_t e;
        int   bad;
        if (rst) begin
            samp1.delete();
            pend1_v    = 1'b0;
            busy_prev1 = 1'b0;
        end else begin
            if (pend1_v) begin
                check(int'(frames_sent) == pend1, "frames_sent", int'(frames_sent), pend1);
                pend1_v = 1'b0;
            end
            if (busy && !busy_prev1) busy_rise1++;
            busy_prev1 = busy;
            if (busy) begin
                busy_cyc1++;
                samp1.push_back(tx);
                if (frame_done) begin
                    if (sb1.size() == 0) begin
                        check(1'b0, "unexpected_frame", 1, 0);
                    end else begin
                        e = sb1.pop_front();
                        check(samp1.size() == 32, "frame_len", samp1.size(), 32);
                        if (samp1.size() == 32) begin
                            bad = -1;
                            for (int k = 0; k < 32; k++)
                                if (samp1[k] !== exp_bit(e.word, k, 4, 1) && bad < 0) bad = k;
                            check(bad < 0, "frame_wave_first_bad_sample", bad, -1);
                        end
                        pend1   = e.cnt;
                        pend1_v = 1'b1;
                    end
                    samp1.delete();
                end
            end else begin
                check(tx === 1'b1 && frame_done === 1'b0, "idle_line", int'({tx, frame_done}), 2);
                samp1.delete();
            end
        end
    end

    // Monitor for instance 2
    always @(negedge clk) begin
        exp_t e;
        int   bad;
        if (rst) begin
            samp2.delete();
            pend2_v    = 1'b0;
            busy_prev2 = 1'b0;
        end else begin
            if (pend2_v) begin
                check(int'(frames_sent2) == pend2, "frames_sent2", int'(frames_sent2), pend2);
                pend2_v = 1'b0;
            end
            if (busy2 && !busy_prev2) busy_rise2++;
            busy_prev2 = busy2;
            if (busy2) begin
                busy_cyc2++;
                samp2.push_back(tx2);
                if (frame_done2) begin
                    if (sb2.size() == 0) begin
                        check(1'b0, "unexpected_frame2", 1, 0);
                    end else begin
                        e = sb2.pop_front();
                        check(samp2.size() == 7, "frame2_len", samp2.size(), 7);
                        if (samp2.size() == 7) begin
                            bad = -1;
                            for (int k = 0; k < 7; k++)
                                if (samp2[k] !== exp_bit(e.word, k, 1, 0) && bad < 0) bad = k;
                            check(bad < 0, "frame2_wave_first_bad_sample", bad, -1);
                        end
                        pend2   = e.cnt;
                        pend2_v = 1'b1;
                    end
                    samp2.delete();
                end
            end else begin
                check(tx2 === 1'b1 && frame_done2 === 1'b0, "idle_line2", int'({tx2, frame_done2}), 2);
                samp2.delete();
            end
        end
    end

    initial begin
        int p0, b0, r0;

        // reset state, with a word waiting so the pop gate is exercised
        rst    = 1'b1;
        enable = 1'b1;
        push1(5'b10110, 1'b1);
        tick();
        tick();
        check(tx === 1'b1, "reset_tx", int'(tx), 1);
        check(busy === 1'b0, "reset_busy", int'(busy), 0);
        check(frame_done === 1'b0, "reset_frame_done", int'(frame_done), 0);
        check(frames_sent === 16'd0, "reset_frames_sent", int'(frames_sent), 0);
        check(fifo_rd_en === 1'b0, "reset_rd_en", int'(fifo_rd_en), 0);

        // single frame
        p0 = pops1;
        b0 = busy_cyc1;
        rst = 1'b0;
        tick();
        check(tx === 1'b0, "t1_start_latency", int'(tx), 0);
        repeat (40) tick();
        check(pops1 - p0 == 1, "t1_pops", pops1 - p0, 1);
        check(busy_cyc1 - b0 == 32, "t1_busy_cycles", busy_cyc1 - b0, 32);
        check(int'(frames_sent) == 1, "t1_frames_sent", int'(frames_sent), 1);
        check(sb1.size() == 0, "t1_frames_missing", sb1.size(), 0);

        // back-to-back frames
        do_reset();
        enable = 1'b1;
        push1(5'h1F, 1'b1);
        push1(5'h00, 1'b1);
        b0 = busy_cyc1;
        r0 = busy_rise1;
        repeat (70) tick();
        check(busy_cyc1 - b0 == 64, "t2_busy_cycles", busy_cyc1 - b0, 64);
        check(busy_rise1 - r0 == 1, "t2_no_gap", busy_rise1 - r0, 1);
        check(int'(frames_sent) == 2, "t2_frames_sent", int'(frames_sent), 2);
        check(sb1.size() == 0, "t2_frames_missing", sb1.size(), 0);

        // empty FIFO
        do_reset();
        enable = 1'b1;
        repeat (100) begin
            tick();
            check({fifo_rd_en, tx, busy, frames_sent} === {1'b0, 1'b1, 1'b0, 16'd0}, "t3_quiet",
                  int'({fifo_rd_en, tx, busy, frames_sent}), int'({1'b0, 1'b1, 1'b0, 16'd0}));
        end

        // enable drop mid-frame
        do_reset();
        enable = 1'b1;
        push1(5'b01001, 1'b1);
        push1(5'b00111, 1'b0);
        p0 = pops1;
        b0 = busy_cyc1;
        tick();
        repeat (9) tick();
        enable = 1'b0;
        repeat (40) tick();
        check(pops1 - p0 == 1, "t4_pops", pops1 - p0, 1);
        check(busy_cyc1 - b0 == 32, "t4_busy_cycles", busy_cyc1 - b0, 32);
        check(int'(frames_sent) == 1, "t4_frames_sent", int'(frames_sent), 1);
        check(tx === 1'b1, "t4_tx_idle", int'(tx), 1);
        check(q1.size() == 1, "t4_word_left", q1.size(), 1);

        // reset mid-frame
        do_reset();
        enable = 1'b1;
        push1(5'b11010, 1'b1);
        tick();
        repeat (11) tick();
        rst = 1'b1;
        tick();
        sb1.delete();
        exp_cnt1 = 0;
        check(tx === 1'b1, "t5_tx", int'(tx), 1);
        check(busy === 1'b0, "t5_busy", int'(busy), 0);
        check(frames_sent === 16'd0, "t5_frames_sent", int'(frames_sent), 0);
        check(frame_done === 1'b0, "t5_frame_done", int'(frame_done), 0);
        tick();
        rst = 1'b0;
        push1(5'b00101, 1'b1);
        repeat (40) tick();
        check(int'(frames_sent) == 1, "t5_clean_frame", int'(frames_sent), 1);
        check(sb1.size() == 0, "t5_frames_missing", sb1.size(), 0);

        // counter wrap on the small instance
        enable2 = 1'b1;
        push2(5'h03);
        push2(5'h1C);
        push2(5'h0A);
        push2(5'h15);
        push2(5'h11);
        b0 = busy_cyc2;
        r0 = busy_rise2;
        repeat (50) tick();
        check(busy_cyc2 - b0 == 35, "t6_busy_cycles", busy_cyc2 - b0, 35);
        check(busy_rise2 - r0 == 1, "t6_no_gap", busy_rise2 - r0, 1);
        check(int'(frames_sent2) == 1, "t6_frames_sent", int'(frames_sent2), 1);
        check(sb2.size() == 0, "t6_frames_missing", sb2.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
